icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001: The block SHALL have parameter S_INDEX, default 4, meaning index bits (2^S_INDEX sets).
REQ-002: The block SHALL have parameter S_OFFSET, default 5, meaning byte-offset bits (32-byte line).
REQ-003: The block SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004: The block SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005: The block SHALL have port i_addr  input  32  word-aligned fetch address from cpu.
REQ-006: The block SHALL have port i_read  input  1  fetch request, held until i_resp.
REQ-007: The block SHALL have port i_rdata  output  32  fetched instruction word.
REQ-008: The block SHALL have port i_resp  output  1  one-cycle completion pulse.
REQ-009: The block SHALL have port pmem_address  output  32  line-aligned memory address.
REQ-010: The block SHALL have port pmem_read  output  1  line read request, held until pmem_resp.
REQ-011: The block SHALL have port pmem_rdata  input  256  returned line.
REQ-012: The block SHALL have port pmem_resp  input  1  line valid, one-cycle pulse.

Function
REQ-013: The block SHALL be direct-mapped and read-only; tag = i_addr[31:S_INDEX+S_OFFSET], index = i_addr[S_INDEX+S_OFFSET-1:S_OFFSET], word select = i_addr[S_OFFSET-1:2].
REQ-014: The FSM SHALL have states CHECK and FETCH; reset state CHECK.
REQ-015: In CHECK with i_read=1, valid[index]=1 and tag match, the block SHALL assert i_resp combinationally that cycle, with i_rdata = word select of data[index] (hit latency 0 extra cycles).
REQ-016: In CHECK with i_read=1 and miss, the block SHALL register the line-aligned address {i_addr[31:S_OFFSET], 0} and move to FETCH next cycle; i_resp SHALL stay 0.
REQ-017: In FETCH, pmem_read SHALL be 1 and pmem_address SHALL equal the registered line address, independent of any change on i_addr.
REQ-018: On pmem_resp in FETCH, the block SHALL write pmem_rdata, tag and valid=1 into the registered index and return to CHECK; request then hits the following cycle (miss latency = memory latency + 1 cycle).
REQ-019: If i_addr changes or i_read drops during FETCH, the block SHALL still complete and install the fetched line, then evaluate the current request in CHECK.
REQ-020: In CHECK, pmem_read SHALL be 0; i_resp SHALL be 0 whenever i_read=0; i_rdata is don't-care when i_resp=0.
REQ-021: A miss on an index holding a valid line SHALL overwrite it (no write-back; lines never dirty).
REQ-022: pmem_resp while in CHECK SHALL be ignored.

Reset
REQ-023: While rst=0 the block SHALL immediately force state CHECK, all valid bits 0, i_resp=0, pmem_read=0, pmem_address=0, registered line address 0.
REQ-024: Reset asserted during FETCH SHALL abort the fetch with pmem_read falling without waiting for a clock; a later pmem_resp SHALL be ignored.
REQ-025: Tag and data arrays need not be reset; valid bits gate all hits.

Structure
REQ-026: The state enum (CHECK, FETCH) and line-width constant (256) SHALL live in a shared package cache_types alongside rv32i_types.
REQ-027: Storage (valid, tag, data arrays with one combinational read port and one synchronous write port) SHALL be a sub-module icache_array; control FSM and muxing stay in icache.

Verification
REQ-028: After reset, i_read=1, i_addr=0x0000_0040 -> pmem_read=1, pmem_address=0x0000_0040 next cycle; pmem_resp after 3 cycles with word1=0x0000_0013 -> i_resp=1 one cycle later with i_rdata word0 of line.
REQ-029: Following REQ-028, i_addr=0x0000_0044 -> i_resp=1 same cycle, i_rdata=0x0000_0013, pmem_read stays 0.
REQ-030: Conflict: i_addr=0x0000_0240 (same index 2, tag differs) -> miss, refill, then 0x0000_0040 misses again.
REQ-031: During FETCH for 0x40, change i_addr to 0x80 -> pmem_address stays 0x40 until pmem_resp, then new miss issued for 0x80.
REQ-032: Assert rst=0 mid-FETCH -> pmem_read falls asynchronously; after release, prior address 0x40 misses (valid cleared).
REQ-033: i_read=0 for 10 cycles with random pmem_resp pulses -> i_resp and pmem_read remain 0, no array write.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared type definitions for the instruction cache.
// rv32i_types holds the CPU-facing word type.
// cache_types holds the cache FSM state and line geometry.

package rv32i_types;
    typedef logic [31:0] rv32i_word;
endpackage

package cache_types;
    localparam int LINE_W = 256;
    localparam int WORD_W = 32;

    typedef enum logic {
        CHECK = 1'b0,
        FETCH = 1'b1
    } cache_state_e;

    typedef logic [LINE_W-1:0] cache_line_t;
endpackage

// File: rtl/icache_array.sv
// Direct-mapped storage for the instruction cache.
// Valid bits are reset; tag and data arrays are not, since valid gates every hit.
// One combinational read port and one synchronous write port.

module icache_array
    import cache_types::*;
#(
    parameter int S_INDEX = 4,
    parameter int TAG_W   = 23
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [S_INDEX-1:0] rd_index_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output cache_line_t        rd_line_o,
    input  logic               we_i,
    input  logic [S_INDEX-1:0] wr_index_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  cache_line_t        wr_line_i
);

    localparam int NSETS = 1 << S_INDEX;

    logic [NSETS-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem  [NSETS];
    cache_line_t      data_mem [NSETS];

    // Valid bits: cleared immediately on reset, set when a line is installed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag and line storage, written together on refill.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_mem[wr_index_i]  <= wr_tag_i;
            data_mem[wr_index_i] <= wr_line_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_mem[rd_index_i];
    assign rd_line_o  = data_mem[rd_index_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache.
// Hits answer in the same cycle; a miss latches the line address, fetches the
// whole line from memory, installs it, and then re-checks the current request.

module icache
    import rv32i_types::*;
    import cache_types::*;
#(
    parameter int S_INDEX  = 4,
    parameter int S_OFFSET = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  rv32i_word   i_addr,
    input  logic        i_read,
    output rv32i_word   i_rdata,
    output logic        i_resp,
    output rv32i_word   pmem_address,
    output logic        pmem_read,
    input  cache_line_t pmem_rdata,
    input  logic        pmem_resp
);

    localparam int TAG_W  = 32 - S_INDEX - S_OFFSET;
    localparam int NWORDS = LINE_W / WORD_W;
    localparam int WSEL_W = S_OFFSET - 2;

    // Address fields of the current request.
    logic [TAG_W-1:0]   req_tag;
    logic [S_INDEX-1:0] req_index;
    logic [WSEL_W-1:0]  req_wsel;
    logic               unused_addr_bits;

    assign req_tag          = i_addr[31:S_INDEX+S_OFFSET];
    assign req_index        = i_addr[S_INDEX+S_OFFSET-1:S_OFFSET];
    assign req_wsel         = i_addr[S_OFFSET-1:2];
    assign unused_addr_bits = ^i_addr[1:0];

    cache_state_e state_q, state_d;
    rv32i_word    line_addr_q, line_addr_d;

    logic         rd_valid;
    logic [TAG_W-1:0] rd_tag;
    cache_line_t  rd_line;
    logic         hit;
    logic         refill_we;

    assign hit       = rd_valid && (rd_tag == req_tag);
    assign refill_we = (state_q == FETCH) && pmem_resp;

    // Refills always target the latched line address, never the live request.
    icache_array #(
        .S_INDEX (S_INDEX),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_index_i (req_index),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_line_o  (rd_line),
        .we_i       (refill_we),
        .wr_index_i (line_addr_q[S_INDEX+S_OFFSET-1:S_OFFSET]),
        .wr_tag_i   (line_addr_q[31:S_INDEX+S_OFFSET]),
        .wr_line_i  (pmem_rdata)
    );

    // Split the selected line into words for the fetch-word mux.
    rv32i_word line_words [NWORDS];
    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_words
            assign line_words[gi] = rd_line[gi*WORD_W +: WORD_W];
        end
    endgenerate

    // Next-state logic: a miss in CHECK latches the line address and starts a
    // fetch; the fetch completes only on memory response, regardless of i_addr.
    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        case (state_q)
            CHECK: begin
                if (i_read && !hit) begin
                    line_addr_d = {i_addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (pmem_resp) begin
                    state_d = CHECK;
                end
            end
            default: state_d = CHECK;
        endcase
    end

    // Controller state; reset aborts any fetch without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= CHECK;
            line_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
        end
    end

    assign i_resp       = (state_q == CHECK) && i_read && hit;
    assign i_rdata      = line_words[req_wsel];
    assign pmem_read    = (state_q == FETCH);
    assign pmem_address = line_addr_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized accesses
// checked against a set-level reference model of a direct-mapped cache.

module tb_icache;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_addr;
    logic         i_read;
    logic [31:0]  i_rdata;
    logic         i_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    always #5 clk = ~clk;

    icache #(.S_INDEX(4), .S_OFFSET(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_addr       (i_addr),
        .i_read       (i_read),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: 16 sets, 32-byte lines, tag = addr / 512.
    bit          m_valid [16];
    logic [31:0] m_tag   [16];

    function automatic int m_index(input logic [31:0] a);
        return int'((a / 32) % 16);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] a);
        return a / 512;
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[m_index(a)] && (m_tag[m_index(a)] == m_tagof(a));
    endfunction

    function automatic void m_install(input logic [31:0] a);
        m_valid[m_index(a)] = 1'b1;
        m_tag[m_index(a)]   = m_tagof(a);
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endfunction

    // Backing memory contents: arbitrary hash, with 0x44 holding 0x13.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0044) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] line_addr(input logic [31:0] a);
        return a - (a % 32);
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = mem_word(la + 32'(w * 4));
        return l;
    endfunction

    // Hold a request until i_resp, serving memory with the given latency.
    task automatic do_access(input logic [31:0] addr, input int lat,
                             output logic [31:0] data, output int cycles,
                             output bit timeout, output bit addr_ok);
        int memcnt = 0;
        bit done = 1'b0;
        i_addr  = addr;
        i_read  = 1'b1;
        cycles  = 0;
        timeout = 1'b0;
        addr_ok = 1'b1;
        data    = '0;
        for (int k = 0; k < 200 && !done; k++) begin
            #1;
            if (i_resp) begin
                data = i_rdata;
                done = 1'b1;
            end else begin
                if (pmem_read) begin
                    if (pmem_address !== line_addr(addr)) addr_ok = 1'b0;
                    memcnt++;
                    if (memcnt == lat) begin
                        pmem_resp  = 1'b1;
                        pmem_rdata = line_of(pmem_address);
                        memcnt     = 0;
                    end
                end
                @(negedge clk);
                pmem_resp = 1'b0;
                cycles++;
            end
        end
        if (!done) timeout = 1'b1;
        $display("access addr=%h lat=%0d cycles=%0d data=%h", addr, lat, cycles, data);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (i_resp !== 1'b0) $display("FAIL reset_i_resp got=%b want=0", i_resp); else n_pass++;
        n_checks++; if (pmem_read !== 1'b0) $display("FAIL reset_pmem_read got=%b want=0", pmem_read); else n_pass++;
        n_checks++; if (pmem_address !== 32'h0) $display("FAIL reset_pmem_address got=%h want=0", pmem_address); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_first_miss_hit();
        logic [31:0] d; int c; bit to, ok;
        do_access(32'h0000_0040, 3, d, c, to, ok);
        m_install(32'h0000_0040);
        n_checks++; if (to || c != 4) $display("FAIL miss40_latency got=%0d want=4 timeout=%b", c, to); else n_pass++;
        n_checks++; if (!ok) $display("FAIL miss40_address got=bad want=00000040"); else n_pass++;
        n_checks++; if (d !== mem_word(32'h40)) $display("FAIL miss40_data got=%h want=%h", d, mem_word(32'h40)); else n_pass++;
        i_addr = 32'h0000_0044;
        #1;
        n_checks++; if (i_resp !== 1'b1 || i_rdata !== 32'h13 || pmem_read !== 1'b0)
            $display("FAIL hit44 got resp=%b data=%h pread=%b want 1/00000013/0", i_resp, i_rdata, pmem_read);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_conflict();
        logic [31:0] d; int c; bit to, ok;
        do_access(32'h0000_0240, 2, d, c, to, ok);
        m_install(32'h0000_0240);
        n_checks++; if (to || c != 3 || d !== mem_word(32'h240))
            $display("FAIL conflict240 got cycles=%0d data=%h want 3/%h", c, d, mem_word(32'h240));
        else n_pass++;
        do_access(32'h0000_0040, 2, d, c, to, ok);
        m_install(32'h0000_0040);
        n_checks++; if (to || c != 3 || d !== mem_word(32'h40))
            $display("FAIL conflict40_remiss got cycles=%0d data=%h want 3/%h", c, d, mem_word(32'h40));
        else n_pass++;
    endtask

    task automatic test_addr_change();
        logic [31:0] d; int c; bit to, ok, stable;
        do_access(32'h0000_0240, 1, d, c, to, ok);
        m_install(32'h0000_0240);
        i_addr = 32'h0000_0040;
        i_read = 1'b1;
        #1;
        n_checks++; if (i_resp !== 1'b0) $display("FAIL chg_miss_resp got=%b want=0", i_resp); else n_pass++;
        @(negedge clk);
        i_addr = 32'h0000_0080;
        stable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (pmem_read !== 1'b1 || pmem_address !== 32'h40) stable = 1'b0;
            if (k == 2) begin
                pmem_resp  = 1'b1;
                pmem_rdata = line_of(32'h40);
            end
            @(negedge clk);
            pmem_resp = 1'b0;
        end
        m_install(32'h0000_0040);
        n_checks++; if (!stable) $display("FAIL chg_addr_stable got=unstable want=00000040"); else n_pass++;
        do_access(32'h0000_0080, 2, d, c, to, ok);
        m_install(32'h0000_0080);
        n_checks++; if (to || !ok || c != 3 || d !== mem_word(32'h80))
            $display("FAIL chg_new_miss got cycles=%0d ok=%b data=%h want 3/1/%h", c, ok, d, mem_word(32'h80));
        else n_pass++;
        do_access(32'h0000_0040, 2, d, c, to, ok);
        n_checks++; if (to || c != 0 || d !== mem_word(32'h40))
            $display("FAIL chg_installed got cycles=%0d data=%h want 0/%h", c, d, mem_word(32'h40));
        else n_pass++;
    endtask

    task automatic test_reset_mid_fetch();
        logic [31:0] d; int c; bit to, ok;
        i_addr = 32'h0000_0240;
        i_read = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (pmem_read !== 1'b1) $display("FAIL rstmid_pre got=%b want=1", pmem_read); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (pmem_read !== 1'b0 || pmem_address !== 32'h0)
            $display("FAIL rstmid_async got pread=%b addr=%h want 0/0", pmem_read, pmem_address);
        else n_pass++;
        m_clear();
        @(negedge clk);
        pmem_resp  = 1'b1;
        pmem_rdata = line_of(32'h240);
        @(negedge clk);
        pmem_resp = 1'b0;
        i_read    = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        n_checks++; if (pmem_read !== 1'b0) $display("FAIL rstmid_late_resp got=%b want=0", pmem_read); else n_pass++;
        @(negedge clk);
        do_access(32'h0000_0040, 3, d, c, to, ok);
        m_install(32'h0000_0040);
        n_checks++; if (to || c != 4 || d !== mem_word(32'h40))
            $display("FAIL rstmid_remiss got cycles=%0d data=%h want 4/%h", c, d, mem_word(32'h40));
        else n_pass++;
    endtask

    task automatic test_idle();
        logic [31:0] d; int c; bit to, ok;
        i_read = 1'b0;
        for (int k = 0; k < 10; k++) begin
            i_addr     = $urandom & 32'hFFFF_FFFC;
            pmem_resp  = 1'($urandom_range(0, 1));
            pmem_rdata = {8{$urandom}};
            #1;
            n_checks++; if (i_resp !== 1'b0 || pmem_read !== 1'b0)
                $display("FAIL idle_cycle%0d got resp=%b pread=%b want 0/0", k, i_resp, pmem_read);
            else n_pass++;
            @(negedge clk);
        end
        pmem_resp = 1'b0;
        do_access(32'h0000_0044, 1, d, c, to, ok);
        n_checks++; if (to || c != 0 || d !== 32'h13)
            $display("FAIL idle_no_write got cycles=%0d data=%h want 0/00000013", c, d);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, d; int lat, c, exp_c; bit to, ok;
        for (int t = 0; t < 40; t++) begin
            a   = (32'($urandom_range(0, 2)) << 9) | (32'($urandom_range(0, 3)) << 5) |
                  (32'($urandom_range(0, 7)) << 2);
            lat = $urandom_range(1, 4);
            exp_c = m_hit(a) ? 0 : lat + 1;
            do_access(a, lat, d, c, to, ok);
            m_install(a);
            n_checks++; if (to || c != exp_c)
                $display("FAIL rand%0d_latency addr=%h got=%0d want=%0d", t, a, c, exp_c);
            else n_pass++;
            n_checks++; if (!ok) $display("FAIL rand%0d_pmem_addr addr=%h got=bad want=%h", t, a, line_addr(a)); else n_pass++;
            n_checks++; if (d !== mem_word(a))
                $display("FAIL rand%0d_data addr=%h got=%h want=%h", t, a, d, mem_word(a));
            else n_pass++;
        end
        i_read = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b0;
        i_addr     = '0;
        i_read     = 1'b0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        m_clear();
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_first_miss_hit();
        test_conflict();
        test_addr_change();
        test_reset_mid_fetch();
        test_idle();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
